// File: rtl/network_stream_adapter.sv
// network_stream_adapter: word-stream glue around the LSTM network core (collect, fire, wait, drain)
module network_stream_adapter #(
   parameter int INPUT_SZ       = 2,
   parameter int OUTPUT_SZ      = 1,
   parameter int QN             = 6,
   parameter int QM             = 11,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int BITWIDTH       = QN + QM + 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [BITWIDTH-1:0]           s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [BITWIDTH*INPUT_SZ-1:0]  net_inputVec,
   output logic                          net_newSample,
   input  logic                          net_dataReady,
   input  logic [BITWIDTH*OUTPUT_SZ-1:0] net_outputVec,
   output logic [BITWIDTH-1:0]           m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          busy,
   output logic                          err_timeout,
   output logic [15:0]                   sample_count
);
   localparam int KW = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1;
   localparam int JW = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(INPUT_SZ - 1);
   localparam logic [JW-1:0] J_LAST = JW'(OUTPUT_SZ - 1);
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_WAIT, ST_DRAIN} state_t;

   state_t                         r_state;
   logic [KW-1:0]                  r_k;
   logic [JW-1:0]                  r_j;
   logic                           r_pending;
   logic                           r_s_ready;
   logic [BITWIDTH*INPUT_SZ-1:0]   r_collect;
   logic [BITWIDTH*INPUT_SZ-1:0]   r_hold;
   logic [BITWIDTH*OUTPUT_SZ-1:0]  r_out;
   logic                           r_dr_q;
   logic                           r_new_sample;
   logic                           r_m_valid;
   logic                           r_err;
   logic [15:0]                    r_count;
   logic [31:0]                    r_wd;

   logic w_accept, w_accept_last, w_take, w_pending_next, w_rise, w_m_fire;

   assign w_accept       = s_valid & r_s_ready;
   assign w_accept_last  = w_accept & (r_k == K_LAST);
   assign w_take         = (r_state == ST_IDLE) & r_pending;
   assign w_pending_next = w_accept_last | (r_pending & ~w_take);
   assign w_rise         = net_dataReady & ~r_dr_q;
   assign w_m_fire       = r_m_valid & m_ready;

   // Collect side: assemble words into the staging vector; ready mirrors the next pending flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_k       <= '0;
         r_pending <= 1'b0;
         r_s_ready <= 1'b0;
         r_collect <= '0;
      end else begin
         r_pending <= w_pending_next;
         r_s_ready <= ~w_pending_next;
         if (w_accept) begin
            r_collect[r_k*BITWIDTH +: BITWIDTH] <= s_data;
            r_k <= w_accept_last ? '0 : r_k + 1'b1;
         end
      end
   end

   // Issue FSM: fire the held vector, wait for a dataReady rising edge, drain the result
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_j          <= '0;
         r_hold       <= '0;
         r_out        <= '0;
         r_dr_q       <= 1'b0;
         r_new_sample <= 1'b0;
         r_m_valid    <= 1'b0;
         r_err        <= 1'b0;
         r_count      <= '0;
         r_wd         <= '0;
      end else begin
         r_dr_q <= net_dataReady;
         case (r_state)
            ST_IDLE: begin
               if (r_pending) begin
                  r_hold       <= r_collect;
                  r_new_sample <= 1'b1;
                  r_state      <= ST_FIRE;
               end
            end
            ST_FIRE: begin
               r_new_sample <= 1'b0;
               r_wd         <= '0;
               r_state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_rise) begin
                  r_out     <= net_outputVec;
                  r_j       <= '0;
                  r_m_valid <= 1'b1;
                  r_state   <= ST_DRAIN;
               end else if (WD_EN && r_wd == WD_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_wd <= r_wd + 32'd1;
               end
            end
            ST_DRAIN: begin
               if (w_m_fire) begin
                  if (r_j == J_LAST) begin
                     r_m_valid <= 1'b0;
                     r_count   <= r_count + 16'd1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s_ready       = r_s_ready;
   assign net_inputVec  = r_hold;
   assign net_newSample = r_new_sample;
   assign m_data        = r_out[r_j*BITWIDTH +: BITWIDTH];
   assign m_valid       = r_m_valid;
   assign busy          = (r_state != ST_IDLE);
   assign err_timeout   = r_err;
   assign sample_count  = r_count;
endmodule

// File: tb/tb_network_stream_adapter.sv
// tb_network_stream_adapter: directed bench for network_stream_adapter with a 20-cycle watchdog
module tb_network_stream_adapter;
   localparam int BW = 18;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [BW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [2*BW-1:0] net_inputVec;
   logic          net_newSample;
   logic          net_dataReady = 1'b0;
   logic [BW-1:0] net_outputVec = '0;
   logic [BW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          busy;
   logic          err_timeout;
   logic [15:0]   sample_count;

   int checks = 0;
   int errors = 0;

   network_stream_adapter #(
      .INPUT_SZ(2), .OUTPUT_SZ(1), .QN(6), .QM(11), .TIMEOUT_CYCLES(20)
   ) dut (
      .clock(clock), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .net_inputVec(net_inputVec), .net_newSample(net_newSample),
      .net_dataReady(net_dataReady), .net_outputVec(net_outputVec),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .err_timeout(err_timeout), .sample_count(sample_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic send_word(input logic [BW-1:0] d);
      s_data  = d;
      s_valid = 1'b1;
      for (int i = 0; i < 40 && s_ready !== 1'b1; i++) @(negedge clock);
      chk("s_ready_wait", s_ready, 1);
      @(negedge clock);
      s_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_inputVec"}, net_inputVec, 0);
      chk({tag, "_newSample"}, net_newSample, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err_timeout, 0);
      chk({tag, "_count"}, sample_count, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      // reset state
      @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b0;
      step(1);
      chk("s_ready_after_reset", s_ready, 1);

      // single sample: 0.0 then 1.0
      send_word(18'h00000);
      send_word(18'h00800);
      chk("single_s_ready_low", s_ready, 0);
      chk("single_ns_before", net_newSample, 0);
      step(1);
      chk("single_ns_pulse", net_newSample, 1);
      chk("single_vec", net_inputVec, {18'h00800, 18'h00000});
      chk("single_s_ready_back", s_ready, 1);
      chk("single_busy", busy, 1);
      step(1);
      chk("single_ns_end", net_newSample, 0);
      chk("single_busy_wait", busy, 1);
      chk("single_no_valid", m_valid, 0);
      net_dataReady = 1'b1;
      net_outputVec = 18'h3F800;
      step(1);
      net_outputVec = 18'h00000;
      // backpressure: hold m_ready low for 10 cycles
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_data", m_data, 18'h3F800);
         chk("bp_count", sample_count, 0);
         step(1);
      end
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      net_dataReady = 1'b0;
      chk("bp_valid_drop", m_valid, 0);
      chk("bp_count1", sample_count, 1);
      chk("bp_idle", busy, 0);

      // overlap: B collected while A waits
      send_word(18'h00111);
      send_word(18'h00222);
      send_word(18'h00333);
      send_word(18'h00444);
      chk("ovl_s_ready_low", s_ready, 0);
      chk("ovl_vec_A", net_inputVec, {18'h00222, 18'h00111});
      chk("ovl_busy", busy, 1);
      net_dataReady = 1'b1;
      net_outputVec = 18'h12345;
      step(1);
      chk("ovl_valid", m_valid, 1);
      chk("ovl_data", m_data, 18'h12345);
      chk("ovl_vec_A_drain", net_inputVec, {18'h00222, 18'h00111});
      chk("ovl_s_ready_still_low", s_ready, 0);
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      net_dataReady = 1'b0;
      chk("ovl_count2", sample_count, 2);
      chk("ovl_idle_gap", busy, 0);
      chk("ovl_ns_gap", net_newSample, 0);
      step(1);
      chk("ovl_B_fire", net_newSample, 1);
      chk("ovl_vec_B", net_inputVec, {18'h00444, 18'h00333});
      chk("ovl_s_ready_B", s_ready, 1);

      // edge detect: dataReady raised in FIRE and held through WAIT
      net_dataReady = 1'b1;
      net_outputVec = 18'h11111;
      step(1);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("edge_no_capture", m_valid, 0);
         chk("edge_busy", busy, 1);
      end
      net_dataReady = 1'b0;
      step(1);
      chk("edge_low_no_capture", m_valid, 0);
      net_dataReady = 1'b1;
      net_outputVec = 18'h2ABCD;
      step(1);
      chk("edge_capture_valid", m_valid, 1);
      chk("edge_capture_data", m_data, 18'h2ABCD);
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      chk("edge_count3", sample_count, 3);
      step(2);
      chk("edge_single_count", sample_count, 3);
      chk("edge_single_valid", m_valid, 0);
      chk("edge_single_busy", busy, 0);
      net_dataReady = 1'b0;

      // watchdog: dataReady never rises
      send_word(18'h3FFFF);
      send_word(18'h20000);
      step(2);
      step(19);
      chk("wd_err_before", err_timeout, 0);
      chk("wd_busy_before", busy, 1);
      step(1);
      chk("wd_err", err_timeout, 1);
      chk("wd_busy", busy, 0);
      chk("wd_count", sample_count, 3);
      chk("wd_vec", net_inputVec, {18'h20000, 18'h3FFFF});

      // next sample after abort still goes through
      send_word(18'h00001);
      send_word(18'h3FFFE);
      step(2);
      chk("post_wd_vec", net_inputVec, {18'h3FFFE, 18'h00001});
      net_dataReady = 1'b1;
      net_outputVec = 18'h00042;
      step(1);
      chk("post_wd_data", m_data, 18'h00042);
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      net_dataReady = 1'b0;
      chk("post_wd_count", sample_count, 4);
      chk("post_wd_err_sticky", err_timeout, 1);

      // async reset mid-DRAIN with a partial word collected
      send_word(18'h00010);
      send_word(18'h00020);
      step(2);
      net_dataReady = 1'b1;
      net_outputVec = 18'h0ABCD;
      step(1);
      chk("ar_drain_valid", m_valid, 1);
      send_word(18'h00777);
      chk("ar_still_drain", m_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk_all_zero("ar");
      @(negedge clock);
      reset = 1'b0;
      net_dataReady = 1'b0;
      send_word(18'h00AAA);
      send_word(18'h00BBB);
      step(1);
      chk("ar_fire", net_newSample, 1);
      chk("ar_vec", net_inputVec, {18'h00BBB, 18'h00AAA});
      chk("ar_count", sample_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/network_stream_adapter.md
Name: network_stream_adapter

Overview:
Upstream/downstream glue for the LSTM `network` core.
- Accepts fixed-point input elements as a word stream (valid/ready) and assembles them into the `inputVec` vector.
- Issues a one-cycle `newSample` pulse to the network and waits for the rising edge of `dataReady`.
- Captures `outputVec` and re-serialises it onto an output word stream with backpressure.
- Assembly of the next sample overlaps with network processing of the current one.

Parameters:
INPUT_SZ, 2, number of input elements per sample
OUTPUT_SZ, 1, number of output elements per result
QN, 6, integer bits of the signed fixed-point format
QM, 11, fractional bits of the signed fixed-point format
TIMEOUT_CYCLES, 0, maximum cycles in WAIT before abort; 0 disables the watchdog
BITWIDTH, QN+QM+1, element width (derived)

Ports:
clock  in  1  single clock, all state updates on its rising edge
reset  in  1  asynchronous, active-high; clears all state
s_data  in  BITWIDTH  input element word
s_valid  in  1  s_data valid
s_ready  out  1  adapter can accept s_data
net_inputVec  out  BITWIDTH*INPUT_SZ  to network inputVec; held stable from fire until the next fire
net_newSample  out  1  to network newSample; registered one-cycle pulse
net_dataReady  in  1  from network dataReady (level)
net_outputVec  in  BITWIDTH*OUTPUT_SZ  from network outputVec
m_data  out  BITWIDTH  output element word
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data
busy  out  1  issue FSM not in IDLE
err_timeout  out  1  sticky; set on watchdog abort; cleared only by reset
sample_count  out  16  number of completed results; wraps 0xFFFF -> 0

Behaviour:
Reset values:
- All outputs are 0, including s_ready (goes to 1 on the first edge after reset deasserts).
- All registers are 0: collect counter, pending, hold register, out register, dr_q, FSM state = IDLE.

Collect side:
- s_ready = ~pending (registered).
- On s_valid & s_ready, the word is written to collect[k*BITWIDTH +: BITWIDTH], k = 0..INPUT_SZ-1, in arrival order, and k increments.
- When word INPUT_SZ-1 is accepted: pending <= 1 and k <= 0.
- No words are accepted while pending = 1.

Issue FSM (IDLE, FIRE, WAIT, DRAIN):
- IDLE: if pending, then hold <= collect, pending <= 0, net_newSample <= 1, go to FIRE.
- Latency: the last input word is accepted at edge N; net_newSample is high during cycle N+1..N+2; s_ready is high again from edge N+1.
- FIRE: net_newSample <= 0, go to WAIT.
- WAIT:
  - dr_q <= net_dataReady every cycle; rise = net_dataReady & ~dr_q.
  - On rise: outreg <= net_outputVec (the value sampled that cycle), j <= 0, m_valid <= 1, go to DRAIN.
  - Watchdog: a counter increments each WAIT cycle. If TIMEOUT_CYCLES ≠ 0 and the count reaches TIMEOUT_CYCLES with no rise: err_timeout <= 1, go to IDLE, sample discarded, sample_count unchanged.
- DRAIN:
  - m_data = outreg[j*BITWIDTH +: BITWIDTH].
  - On m_valid & m_ready: j increments. On word OUTPUT_SZ-1: m_valid <= 0, sample_count += 1, go to IDLE.
  - m_data and m_valid hold while m_ready = 0.

Boundary conditions:
- A dataReady rise outside WAIT is ignored (dr_q still tracks it).
- If dataReady is already high on entering WAIT, no rise is detected until it falls and rises again.
- pending set in DRAIN is serviced on the first IDLE cycle, giving back-to-back samples with 1 idle cycle.
- net_inputVec = hold, unchanged during WAIT/DRAIN even while new words are being collected.
- Reset mid-operation: immediate return to the reset state; partial collect words are discarded.
- No arithmetic on data: words are passed through bit-exact, signed two's complement.

Test Plan:
- Single sample: words 0x00000 then 0x00800 (1.0 in Q6.11) → net_inputVec = {18'h00800, 18'h00000}; net_newSample high for exactly 1 cycle, 1 cycle after the 2nd accept; raise dataReady with outputVec = 0x3F800 → m_data = 0x3F800, m_valid until accepted; sample_count = 1.
- Backpressure: m_ready held low 10 cycles after the result → m_valid and m_data stable for all 10 cycles; m_ready = 1 → one handshake, FSM returns to IDLE.
- Overlap: feed sample B's 2 words during WAIT for sample A → s_ready drops after B completes; net_inputVec stays A until A is drained; B fires 1 cycle after A's last m handshake.
- Edge detect: dataReady high before fire and held high → no capture; drop 1 cycle then raise → exactly one capture.
- Watchdog: TIMEOUT_CYCLES = 20, never raise dataReady → err_timeout = 1 after 20 WAIT cycles, busy = 0, sample_count unchanged, next sample still processed.
- Async reset: assert reset in DRAIN between clock edges → all outputs 0 immediately; after release, one word sent then a full sample → first vector equals the post-reset words only.
